// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus target: FSM encoding, default window
// base and the byte-lane merge used when a write commits.
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACK  = 3'd2,
    ST_HOLD = 3'd3,
    ST_SKIP = 3'd4
  } bus_state_e;

  // Word address [23:1] of the window start (byte address 0xF00000).
  localparam logic [23:1] DEFAULT_BASE_ADDR = 23'h780000;

  // A lane is replaced only when its (active-low) data strobe is asserted.
  function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic        uds_n,
                                             input logic        lds_n);
    lane_merge = {uds_n ? old_v[15:8] : new_v[15:8],
                  lds_n ? old_v[7:0]  : new_v[7:0]};
  endfunction

endpackage

// File: rtl/m68k_sig_sync.sv
// Two-flop synchronizer for the asynchronous 68000 strobes. Resets to all
// ones so that every active-low strobe reads as deasserted out of reset.
module m68k_sig_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // Shift the raw inputs through two stages.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/m68k_bus_target.sv
// Responder end of the asynchronous 68000 bus cycle. Decodes a word window,
// serves reads/writes on a small flop register bank with byte-lane masking,
// inserts WAIT_STATES extra cycles and acknowledges with an open-drain DTACK.
//
// Handshake: a cycle is accepted when synced AS and at least one synced data
// strobe are low inside the window; DTACK_n is held low from ACK through HOLD
// and released in the cycle synced AS is seen high. A new cycle is never
// accepted before AS has been observed high, so cycles never overlap.
module m68k_bus_target
  import m68k_bus_pkg::*;
#(
  parameter logic [23:1] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          ADDR_BITS   = 4,
  parameter int          WAIT_STATES = 2
) (
  input  logic                 M68K_CLK,
  input  logic                 M68K_RESET_n,
  input  logic [23:1]          M68K_A,
  inout  wire  [15:0]          M68K_D,
  input  logic                 M68K_AS_n,
  input  logic                 M68K_UDS_n,
  input  logic                 M68K_LDS_n,
  input  logic                 M68K_RW,
  output logic                 M68K_DTACK_n,
  output logic                 REG_WSTB,
  output logic [ADDR_BITS-1:0] REG_WIDX,
  output logic [15:0]          REG_WDATA,
  output logic [2:0]           dbg_state_o
);

  localparam int NREG = 1 << ADDR_BITS;

  bus_state_e           state_q;
  logic [3:0]           cnt_q;
  logic                 dtack_q;
  logic                 oe_q;
  logic                 rw_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 wstb_q;
  logic [ADDR_BITS-1:0] widx_q;
  logic [15:0]          wdata_q;
  logic                 armed_q;
  logic [1:0]           flush_q;
  logic [15:0]          bank_q [NREG];

  logic                 as_n_s, uds_n_s, lds_n_s, rw_s;
  logic                 hit_d;
  logic                 ds_d;
  logic [ADDR_BITS-1:0] idx_d;
  logic [15:0]          merge_d;

  m68k_sig_sync #(.WIDTH(4)) u_sync (
    .clk_i   (M68K_CLK),
    .rst_n_i (M68K_RESET_n),
    .d_i     ({M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW}),
    .q_o     ({as_n_s, uds_n_s, lds_n_s, rw_s})
  );

  // Address and data are only looked at while synced AS is low (bus stable).
  assign hit_d   = !as_n_s && (M68K_A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);
  assign ds_d    = !(uds_n_s & lds_n_s);
  assign idx_d   = M68K_A[ADDR_BITS:1];
  assign merge_d = lane_merge(bank_q[idx_q], M68K_D, uds_n_s, lds_n_s);

  // Bus-cycle FSM with registered DTACK/read-enable, write commit and bank.
  always_ff @(posedge M68K_CLK) begin
    if (!M68K_RESET_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dtack_q <= 1'b0;
      oe_q    <= 1'b0;
      rw_q    <= 1'b1;
      idx_q   <= '0;
      wstb_q  <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      armed_q <= 1'b0;
      flush_q <= '0;
      for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
    end else begin
      wstb_q <= 1'b0;
      // The synchronizer holds reset ones for two cycles; only trust AS high
      // after it has flushed, so a cycle already in progress is ignored.
      if (flush_q != 2'd2) flush_q <= flush_q + 2'd1;
      if (flush_q == 2'd2 && as_n_s) armed_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (armed_q && !as_n_s) begin
            if (!hit_d) begin
              state_q <= ST_SKIP;
            end else if (ds_d) begin
              state_q <= ST_WAIT;
              cnt_q   <= 4'(WAIT_STATES);
              idx_q   <= idx_d;
              rw_q    <= rw_s;
              oe_q    <= rw_s;
            end
          end
        end
        ST_WAIT: begin
          if (as_n_s) begin
            state_q <= ST_IDLE;
            oe_q    <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == 4'd0) begin
            state_q <= ST_ACK;
            dtack_q <= 1'b1;
            if (!rw_q) begin
              bank_q[idx_q] <= merge_d;
              wstb_q        <= 1'b1;
              widx_q        <= idx_q;
              wdata_q       <= merge_d;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ACK: state_q <= ST_HOLD;
        ST_HOLD: begin
          if (as_n_s) begin
            state_q <= ST_IDLE;
            dtack_q <= 1'b0;
            oe_q    <= 1'b0;
          end
        end
        ST_SKIP: begin
          if (as_n_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign M68K_DTACK_n = dtack_q ? 1'b0 : 1'bz;
  assign M68K_D       = oe_q ? bank_q[idx_q] : 16'hzzzz;
  assign REG_WSTB     = wstb_q;
  assign REG_WIDX     = widx_q;
  assign REG_WDATA    = wdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Bench for m68k_bus_target: two targets on one bus (WAIT_STATES 2 and 4,
// different windows), reference register models and scoreboard queues.
module tb_m68k_bus_target;
  import m68k_bus_pkg::*;

  localparam logic [23:1] BASE1 = 23'h780000;
  localparam logic [23:1] BASE2 = 23'h700000;
  localparam int          WS1   = 2;
  localparam int          WS2   = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:1] a = '0;
  logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic [15:0] tb_d = '0;
  logic        tb_d_oe = 1'b0;
  tri1  [15:0] m68k_d;
  tri1         dtack1_n, dtack2_n;
  logic        wstb1, wstb2;
  logic [3:0]  widx1, widx2;
  logic [15:0] wdata1, wdata2;
  logic [2:0]  st1, st2;

  int errors = 0;
  int checks = 0;
  int wcnt1 = 0, wcnt2 = 0;
  logic [15:0] mem1 [16];
  logic [15:0] mem2 [16];
  logic [15:0] exp_q [$];
  logic [19:0] wexp_q [$];

  assign m68k_d = tb_d_oe ? tb_d : 16'hzzzz;

  m68k_bus_target #(.BASE_ADDR(BASE1), .ADDR_BITS(4), .WAIT_STATES(WS1)) u_dut1 (
    .M68K_CLK(clk), .M68K_RESET_n(reset_n), .M68K_A(a), .M68K_D(m68k_d),
    .M68K_AS_n(as_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
    .M68K_DTACK_n(dtack1_n), .REG_WSTB(wstb1), .REG_WIDX(widx1),
    .REG_WDATA(wdata1), .dbg_state_o(st1)
  );

  m68k_bus_target #(.BASE_ADDR(BASE2), .ADDR_BITS(4), .WAIT_STATES(WS2)) u_dut2 (
    .M68K_CLK(clk), .M68K_RESET_n(reset_n), .M68K_A(a), .M68K_D(m68k_d),
    .M68K_AS_n(as_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
    .M68K_DTACK_n(dtack2_n), .REG_WSTB(wstb2), .REG_WIDX(widx2),
    .REG_WDATA(wdata2), .dbg_state_o(st2)
  );

  // ---------------- clock / reset / monitors ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wstb1 === 1'b1) wcnt1++;
    if (wstb2 === 1'b1) wcnt2++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic dtack_of(input int dut);
    return (dut == 1) ? dtack1_n : dtack2_n;
  endfunction

  function automatic logic [23:1] base_of(input int dut);
    return (dut == 1) ? BASE1 : BASE2;
  endfunction

  function automatic int ws_of(input int dut);
    return (dut == 1) ? WS1 : WS2;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 16'h0000;
      mem2[i] = 16'h0000;
    end
  endtask

  // One complete bus cycle. lat = negedges from strobe assertion until
  // DTACK low (-1 if never), pre = D one cycle before DTACK, rel = negedges
  // from AS release until DTACK released, drv = D seen driven by a target.
  task automatic bus_cycle(input logic [23:1] addr, input logic rd_n_wr,
                           input logic u_n, input logic l_n, input logic [15:0] wd,
                           input int dut, output int lat, output logic [15:0] rd,
                           output logic [15:0] pre, output int rel, output logic drv);
    logic [15:0] last;
    lat = -1; rd = 16'hxxxx; pre = 16'hxxxx; rel = -1; drv = 1'b0;
    last = 16'hxxxx;
    @(negedge clk);
    a = addr; rw = rd_n_wr; tb_d = wd; tb_d_oe = !rd_n_wr;
    as_n = 1'b0; uds_n = u_n; lds_n = l_n;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!tb_d_oe && m68k_d !== 16'hFFFF) drv = 1'b1;
      if (dtack_of(dut) === 1'b0) begin
        lat = i;
        rd  = m68k_d;
        pre = last;
        break;
      end
      last = m68k_d;
    end
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; tb_d_oe = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (dtack_of(dut) === 1'b1) begin
        rel = i;
        break;
      end
    end
  endtask

  task automatic do_read(input int dut, input int idx, input string tag);
    int lat, rel;
    logic [15:0] rd, pre, exp;
    logic drv;
    exp_q.push_back((dut == 1) ? mem1[idx] : mem2[idx]);
    bus_cycle(base_of(dut) + 23'(idx), 1'b1, 1'b0, 1'b0, 16'h0000, dut, lat, rd, pre, rel, drv);
    exp = exp_q.pop_front();
    checks++;
    if (lat != ws_of(dut) + 4) begin
      errors++;
      $display("FAIL %s read_latency: got %0d cycles, want %0d", tag, lat, ws_of(dut) + 4);
    end
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL %s read_data: got %h, want %h", tag, rd, exp);
    end
    checks++;
    if (pre !== exp) begin
      errors++;
      $display("FAIL %s read_data_early: got %h, want %h", tag, pre, exp);
    end
    checks++;
    if (rel < 2 || rel > 3) begin
      errors++;
      $display("FAIL %s dtack_release: got %0d cycles, want 2..3", tag, rel);
    end
  endtask

  task automatic do_write(input int dut, input int idx, input logic [15:0] data,
                          input logic u_n, input logic l_n, input string tag);
    int lat, rel, c0, c1;
    logic [15:0] rd, pre, old_v, merged;
    logic [19:0] exp;
    logic drv;
    old_v  = (dut == 1) ? mem1[idx] : mem2[idx];
    merged = old_v;
    if (!u_n) merged[15:8] = data[15:8];
    if (!l_n) merged[7:0]  = data[7:0];
    if (dut == 1) mem1[idx] = merged; else mem2[idx] = merged;
    wexp_q.push_back({4'(idx), merged});
    c0 = (dut == 1) ? wcnt1 : wcnt2;
    bus_cycle(base_of(dut) + 23'(idx), 1'b0, u_n, l_n, data, dut, lat, rd, pre, rel, drv);
    c1 = (dut == 1) ? wcnt1 : wcnt2;
    exp = wexp_q.pop_front();
    checks++;
    if (lat != ws_of(dut) + 4) begin
      errors++;
      $display("FAIL %s write_latency: got %0d cycles, want %0d", tag, lat, ws_of(dut) + 4);
    end
    checks++;
    if (c1 - c0 != 1) begin
      errors++;
      $display("FAIL %s wstb_pulses: got %0d, want 1", tag, c1 - c0);
    end
    checks++;
    if (((dut == 1) ? {widx1, wdata1} : {widx2, wdata2}) !== exp) begin
      errors++;
      $display("FAIL %s widx_wdata: got %h, want %h", tag,
               (dut == 1) ? {widx1, wdata1} : {widx2, wdata2}, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    clear_models();
    @(negedge clk);
    checks++;
    if (dtack1_n !== 1'b1 || dtack2_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_dtack: got %b%b, want 11 (released)", dtack1_n, dtack2_n);
    end
    checks++;
    if (m68k_d !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_data: got %h, want FFFF (released)", m68k_d);
    end
    checks++;
    if ({wstb1, widx1, wdata1} !== 21'd0 || {wstb2, widx2, wdata2} !== 21'd0) begin
      errors++;
      $display("FAIL reset_wport: got %h/%h, want 0/0", {wstb1, widx1, wdata1}, {wstb2, widx2, wdata2});
    end
    checks++;
    if (st1 !== 3'(ST_IDLE) || st2 !== 3'(ST_IDLE)) begin
      errors++;
      $display("FAIL reset_state: got %0d/%0d, want %0d", st1, st2, ST_IDLE);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_first_read();
    do_read(1, 3, "first_read");
  endtask

  task automatic test_word_rw();
    do_write(1, 0, 16'h1234, 1'b0, 1'b0, "word_wr");
    do_read(1, 0, "word_rd");
  endtask

  task automatic test_lanes();
    do_write(1, 1, 16'hAAAA, 1'b0, 1'b0, "lane_preload");
    do_write(1, 1, 16'h55C3, 1'b0, 1'b1, "lane_upper_wr");
    do_read(1, 1, "lane_upper_rd");
    do_write(1, 1, 16'h9911, 1'b1, 1'b0, "lane_lower_wr");
    do_read(1, 1, "lane_lower_rd");
    checks++;
    if (mem1[1] !== 16'h5511) begin
      errors++;
      $display("FAIL lane_model: got %h, want 5511", mem1[1]);
    end
  endtask

  task automatic test_miss();
    int lat, rel, c0;
    logic [15:0] rd, pre;
    logic drv;
    c0 = wcnt1 + wcnt2;
    bus_cycle(BASE1 + 23'd16, 1'b1, 1'b0, 1'b0, 16'h0000, 1, lat, rd, pre, rel, drv);
    checks++;
    if (lat != -1) begin
      errors++;
      $display("FAIL miss_rd_dtack: got ack after %0d cycles, want none", lat);
    end
    checks++;
    if (drv !== 1'b0) begin
      errors++;
      $display("FAIL miss_rd_data: got driven bus, want released");
    end
    bus_cycle(BASE1 + 23'd16, 1'b0, 1'b0, 1'b0, 16'hDEAD, 1, lat, rd, pre, rel, drv);
    checks++;
    if (lat != -1 || wcnt1 + wcnt2 != c0) begin
      errors++;
      $display("FAIL miss_wr: got ack=%0d strobes=%0d, want ack=-1 strobes=0", lat, wcnt1 + wcnt2 - c0);
    end
    do_write(1, 5, 16'h0A5A, 1'b0, 1'b0, "after_miss_wr");
    do_read(1, 5, "after_miss_rd");
  endtask

  task automatic test_abort();
    logic saw_ack;
    logic [2:0] st_at3;
    int c0;
    do_write(2, 2, 16'hBEEF, 1'b0, 1'b0, "abort_preload");
    c0 = wcnt2;
    saw_ack = 1'b0;
    st_at3 = 3'd7;
    @(negedge clk);
    a = BASE2 + 23'd2; rw = 1'b0; tb_d = 16'h0F0F; tb_d_oe = 1'b1;
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    @(negedge clk);
    as_n = 1'b1;
    for (int i = 2; i <= 14; i++) begin
      @(negedge clk);
      if (i == 3) st_at3 = st2;
      if (i == 4) begin
        uds_n = 1'b1; lds_n = 1'b1; tb_d_oe = 1'b0;
      end
      if (dtack2_n === 1'b0) saw_ack = 1'b1;
    end
    checks++;
    if (st_at3 !== 3'(ST_WAIT)) begin
      errors++;
      $display("FAIL abort_in_wait: got state %0d, want %0d", st_at3, ST_WAIT);
    end
    checks++;
    if (saw_ack !== 1'b0 || wcnt2 != c0) begin
      errors++;
      $display("FAIL abort_ack_commit: got ack=%b strobes=%0d, want 0/0", saw_ack, wcnt2 - c0);
    end
    checks++;
    if (st2 !== 3'(ST_IDLE)) begin
      errors++;
      $display("FAIL abort_idle: got state %0d, want %0d", st2, ST_IDLE);
    end
    do_read(2, 2, "abort_readback");
  endtask

  task automatic test_back_to_back();
    int idx, lane;
    logic [15:0] data;
    for (int i = 0; i < 10; i++) begin
      idx  = $urandom_range(0, 15);
      lane = $urandom_range(0, 2);
      data = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_write(1, idx, data, lane == 2, lane == 1, "b2b_wr");
      else
        do_read(1, idx, "b2b_rd");
    end
  endtask

  task automatic test_reset_hold();
    int lat;
    logic saw_ack;
    do_write(1, 7, 16'hC0DE, 1'b0, 1'b0, "rh_preload");
    lat = -1;
    @(negedge clk);
    a = BASE1 + 23'd7; rw = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dtack1_n === 1'b0) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (lat == -1 || st1 !== 3'(ST_HOLD)) begin
      errors++;
      $display("FAIL rh_hold: got lat=%0d state=%0d, want ack and state %0d", lat, st1, ST_HOLD);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (dtack1_n !== 1'b1 || m68k_d !== 16'hFFFF) begin
      errors++;
      $display("FAIL rh_release: got dtack=%b d=%h, want 1/FFFF", dtack1_n, m68k_d);
    end
    reset_n = 1'b1;
    clear_models();
    saw_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dtack1_n === 1'b0) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack !== 1'b0 || st1 !== 3'(ST_IDLE)) begin
      errors++;
      $display("FAIL rh_ignore: got ack=%b state=%0d, want 0/%0d", saw_ack, st1, ST_IDLE);
    end
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    repeat (4) @(negedge clk);
    do_read(1, 7, "rh_cleared7");
    do_read(1, 0, "rh_cleared0");
    do_read(2, 2, "rh_cleared_t2");
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    test_first_read();
    test_word_rw();
    test_lanes();
    test_miss();
    test_abort();
    test_back_to_back();
    test_reset_hold();
    checks++;
    if (exp_q.size() != 0 || wexp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d left, want 0/0", exp_q.size(), wexp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
